// File: rtl/sd_stream_buffer.sv
// rtl/sd_stream_buffer.sv - SD multi-block read streamer with byte FIFO and 16-bit PCM sample output
// Build option: SD_STREAM_HOLD_ON_UNDERRUN_EN holds sample_out on underrun instead of emitting silence.
module sd_stream_buffer #(
    parameter int FIFO_DEPTH  = 1024,
    parameter int BLOCK_BYTES = 512,
    parameter int ADDR_BITS   = 32,
    parameter int IDX_BITS    = 9
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        stop,
    input  logic [ADDR_BITS-1:0]        start_addr,
    input  logic                        card_configured,
    input  logic                        blk_card_ready,
    input  logic [7:0]                  blk_data,
    input  logic [IDX_BITS-1:0]         blk_idx,
    input  logic                        blk_new,
    output logic                        blk_trigger,
    output logic                        blk_continuous,
    output logic [ADDR_BITS-1:0]        blk_addr,
    input  logic                        sample_tick,
    output logic [15:0]                 sample_out,
    output logic                        underrun,
    output logic                        overrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0]    FULL_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0]    ROOM_MAX = LVL_W'(FIFO_DEPTH - BLOCK_BYTES);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(BLOCK_BYTES - 1);
`ifdef SD_STREAM_HOLD_ON_UNDERRUN_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, LAUNCH, STREAM} state_t;

    state_t               state;
    logic [ADDR_BITS-1:0] cur_addr;
    logic                 stop_pend;
    logic [7:0]           mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     rd_nxt;
    logic                 room;
    logic                 full;
    logic                 flush;
    logic                 wr_req;
    logic                 wr_en;
    logic                 pop;

    assign room   = fifo_level <= ROOM_MAX;
    assign full   = fifo_level == FULL_LVL;
    assign flush  = (state == IDLE) && start && card_configured;
    assign wr_req = blk_new && (state != IDLE);
    assign wr_en  = wr_req && !full;
    assign pop    = sample_tick && (fifo_level >= LVL_W'(2)) && !flush;
    assign rd_nxt = rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= blk_data;
    end

    // Both bytes of a sample leave in one cycle: lo at rd_ptr, hi right after it.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            underrun   <= 1'b0;
            overrun    <= 1'b0;
            if (!rst_n) sample_out <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + PTR_W'(2);
            fifo_level <= fifo_level + LVL_W'(wr_en) - (pop ? LVL_W'(2) : LVL_W'(0));
            if (wr_req && full) overrun <= 1'b1;
            if (pop) begin
                sample_out <= {mem[rd_nxt], mem[rd_ptr]};
            end else if (sample_tick) begin
                underrun <= 1'b1;
                if (!HOLD) sample_out <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cur_addr       <= '0;
            stop_pend      <= 1'b0;
            blk_trigger    <= 1'b0;
            blk_continuous <= 1'b0;
            blk_addr       <= '0;
            busy           <= 1'b0;
        end else begin
            if (stop && state != IDLE) stop_pend <= 1'b1;
            if (state == STREAM && blk_new && blk_idx == LAST_IDX) cur_addr <= cur_addr + 1'b1;
            case (state)
                IDLE: begin
                    if (start && card_configured) begin
                        cur_addr       <= start_addr;
                        stop_pend      <= 1'b0;
                        state          <= WAIT;
                        busy           <= 1'b1;
                        blk_continuous <= 1'b1;
                    end
                end
                WAIT: begin
                    if (stop_pend) begin
                        state          <= IDLE;
                        busy           <= 1'b0;
                        blk_continuous <= 1'b0;
                    end else if (blk_card_ready && room) begin
                        blk_addr    <= cur_addr;
                        blk_trigger <= 1'b1;
                        state       <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (!blk_card_ready) state <= STREAM;
                end
                STREAM: begin
                    // Card back to ready means the multi-block read has ended (CMD12 done).
                    if (blk_card_ready) begin
                        blk_trigger <= 1'b0;
                        if (stop_pend) begin
                            state          <= IDLE;
                            busy           <= 1'b0;
                            blk_continuous <= 1'b0;
                        end else begin
                            state <= WAIT;
                        end
                    end else begin
                        blk_trigger <= room && !stop_pend;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_stream_buffer.sv
// tb/tb_sd_stream_buffer.sv - self-checking bench: control vector table plus card model against a byte-queue reference
`timescale 1ns/1ps
module tb_sd_stream_buffer;
`ifdef SD_STREAM_HOLD_ON_UNDERRUN_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, start, stop, card_configured, blk_card_ready, blk_new, sample_tick;
    logic [31:0] start_addr;
    logic [7:0]  blk_data;
    logic [8:0]  blk_idx;
    logic        blk_trigger, blk_continuous, underrun, overrun, busy;
    logic [31:0] blk_addr;
    logic [15:0] sample_out;
    logic [10:0] fifo_level;

    always #5 clk = ~clk;

    sd_stream_buffer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .start_addr(start_addr),
        .card_configured(card_configured), .blk_card_ready(blk_card_ready),
        .blk_data(blk_data), .blk_idx(blk_idx), .blk_new(blk_new),
        .blk_trigger(blk_trigger), .blk_continuous(blk_continuous), .blk_addr(blk_addr),
        .sample_tick(sample_tick), .sample_out(sample_out), .underrun(underrun),
        .overrun(overrun), .fifo_level(fifo_level), .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          st, sp, cfg, rdy;
        bit          e_busy, e_trig;
        logic [31:0] e_addr;
    } vec_t;
    vec_t tbl[16];

    // Reference: the FIFO is just a queue of bytes; samples pair the two oldest bytes.
    byte unsigned mq[$];
    logic [15:0]  m_sample;
    bit           m_under, m_over;

    typedef enum {C_IDLE, C_DATA, C_CRC, C_END} cst_t;
    cst_t        cst;
    int          c_idx, c_wait, blocks_done;
    logic [31:0] sess_start, last_launch;
    bit          card_en, force_byte, force_tick, do_start, do_stop;
    int          tick_pct, byte_pct;
    byte unsigned force_val;

    task automatic step();
        bit tk, nb, pop, full_pre;
        byte unsigned d, lo, hi;
        chk("fifo_level", fifo_level, mq.size());
        chk("sample_out", sample_out, m_sample);
        chk("underrun", underrun, m_under);
        chk("overrun", overrun, m_over);
        nb = 0; d = 0;
        blk_new = 0;
        case (cst)
            C_IDLE: begin
                if (card_en && blk_card_ready && blk_trigger) begin
                    chk("launch_addr", blk_addr, sess_start + blocks_done);
                    chk("launch_continuous", blk_continuous, 1);
                    last_launch = blk_addr;
                    c_idx = 0;
                    blk_card_ready = 0;
                    cst = C_DATA;
                end else begin
                    blk_card_ready = card_en;
                end
            end
            C_DATA: begin
                if ($urandom_range(99) < byte_pct) begin
                    d = 8'(c_idx + 5 * blocks_done);
                    nb = 1;
                    blk_new = 1; blk_idx = 9'(c_idx); blk_data = d;
                    if (c_idx == 511) begin
                        blocks_done++;
                        c_wait = 3;
                        cst = C_CRC;
                    end
                    c_idx++;
                end
            end
            C_CRC: begin
                if (c_wait > 0) c_wait--;
                else if (blk_trigger) begin c_idx = 0; cst = C_DATA; end
                else begin c_wait = 3; cst = C_END; end
            end
            C_END: begin
                if (c_wait > 0) c_wait--;
                else begin cst = C_IDLE; blk_card_ready = card_en; end
            end
        endcase
        if (force_byte && !nb) begin
            nb = 1; d = force_val;
            blk_new = 1; blk_idx = 9'd3; blk_data = force_val;
        end
        tk = force_tick || ($urandom_range(99) < tick_pct);
        sample_tick = tk;
        start = do_start;
        stop = do_stop;
        if (do_start) begin
            mq.delete(); m_under = 0; m_over = 0;
            sess_start = start_addr; blocks_done = 0;
        end else begin
            full_pre = mq.size() >= 1024;
            pop = tk && mq.size() >= 2;
            if (pop) begin
                lo = mq.pop_front(); hi = mq.pop_front();
                m_sample = {hi, lo};
            end else if (tk) begin
                m_under = 1;
                if (!HOLD) m_sample = 16'h0000;
            end
            if (nb) begin
                if (full_pre) m_over = 1;
                else mq.push_back(d);
            end
        end
        do_start = 0; do_stop = 0; force_byte = 0; force_tick = 0;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bit ok;
        int bd;
        logic [15:0] prev;
        tbl[0]  = '{0,0,1,0, 0,0,0};
        tbl[1]  = '{1,0,0,0, 0,0,0};
        tbl[2]  = '{0,1,1,0, 0,0,0};
        tbl[3]  = '{1,0,1,0, 1,0,0};
        tbl[4]  = '{0,0,1,0, 1,0,0};
        tbl[5]  = '{1,0,1,0, 1,0,0};
        tbl[6]  = '{0,1,1,0, 1,0,0};
        tbl[7]  = '{0,0,1,0, 0,0,0};
        tbl[8]  = '{1,0,1,1, 1,0,0};
        tbl[9]  = '{0,0,1,1, 1,1,100};
        tbl[10] = '{0,0,1,1, 1,1,100};
        tbl[11] = '{0,0,1,0, 1,1,100};
        tbl[12] = '{0,0,1,0, 1,1,100};
        tbl[13] = '{0,1,1,0, 1,1,100};
        tbl[14] = '{0,0,1,0, 1,0,100};
        tbl[15] = '{0,0,1,1, 0,0,100};

        rst_n = 0; start = 0; stop = 0; card_configured = 0; blk_card_ready = 0;
        blk_new = 0; blk_data = 0; blk_idx = 0; sample_tick = 0; start_addr = 100;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            start = tbl[i].st; stop = tbl[i].sp;
            card_configured = tbl[i].cfg; blk_card_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_cont", i), blk_continuous, tbl[i].e_busy);
            chk($sformatf("tbl%0d_trig", i), blk_trigger, tbl[i].e_trig);
            chk($sformatf("tbl%0d_addr", i), blk_addr, tbl[i].e_addr);
        end

        // Reset while start is asserted.
        rst_n = 0; start = 1; card_configured = 1; blk_card_ready = 1;
        blk_new = 1; sample_tick = 1; stop = 0;
        repeat (3) @(negedge clk);
        chk("rst_trig", blk_trigger, 0);
        chk("rst_cont", blk_continuous, 0);
        chk("rst_addr", blk_addr, 0);
        chk("rst_sample", sample_out, 0);
        chk("rst_under", underrun, 0);
        chk("rst_over", overrun, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1; start = 0; blk_new = 0; sample_tick = 0; blk_card_ready = 0;
        @(negedge clk);
        chk("rst_busy_after", busy, 0);

        m_sample = 0; m_under = 0; m_over = 0; cst = C_IDLE;
        card_en = 0; tick_pct = 0; byte_pct = 100; blocks_done = 0; sess_start = 0;
        force_byte = 0; force_tick = 0; do_start = 0; do_stop = 0; last_launch = 0;

        // Two blocks fill the FIFO with no ticks; card must be told to stop.
        start_addr = 100; do_start = 1; card_en = 1;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (cst == C_IDLE && blocks_done >= 2) begin ok = 1; break; end
        end
        chk("fill_timeout", ok, 1);
        run(10);
        chk("fill_level", fifo_level, 1024);
        chk("fill_trig", blk_trigger, 0);
        chk("fill_busy", busy, 1);
        chk("fill_launch", last_launch, 100);

        force_tick = 1; step(); step();
        chk("first_sample", sample_out, 16'h0100);
        for (int i = 0; i < 127; i++) begin force_tick = 1; step(); step(); end
        run(10);
        chk("quarter_level", fifo_level, 768);
        chk("quarter_trig", blk_trigger, 0);
        chk("quarter_launch", last_launch, 100);
        for (int i = 0; i < 128; i++) begin force_tick = 1; step(); step(); end
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (cst == C_DATA) begin ok = 1; break; end
            step();
        end
        chk("relaunch_timeout", ok, 1);
        chk("relaunch_addr", last_launch, 102);

        // Refill, then push one extra byte into the full FIFO.
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (cst == C_IDLE && blocks_done >= 3) begin ok = 1; break; end
        end
        chk("refill_timeout", ok, 1);
        run(10);
        force_byte = 1; force_val = 8'hEE; step(); step();
        chk("overrun_flag", overrun, 1);
        chk("overrun_level", fifo_level, 1024);

        tick_pct = 25; byte_pct = 75;
        run(4000);

        // Stop in the middle of a block.
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (cst == C_DATA && c_idx > 100 && c_idx < 400) begin ok = 1; break; end
            step();
        end
        chk("midblock_timeout", ok, 1);
        bd = blocks_done;
        do_stop = 1; step();
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (!busy) begin ok = 1; break; end
        end
        chk("stop_timeout", ok, 1);
        chk("stop_blocks", blocks_done, bd + 1);
        chk("stop_trig", blk_trigger, 0);
        chk("stop_cont", blk_continuous, 0);
        card_en = 0; tick_pct = 50;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (fifo_level < 2) begin ok = 1; break; end
        end
        chk("drain_timeout", ok, 1);
        run(5);

        // Underrun with exactly one byte buffered; start clears overrun.
        tick_pct = 0; start_addr = 7; do_start = 1; step(); step();
        chk("restart_over", overrun, 0);
        chk("restart_level", fifo_level, 0);
        chk("restart_busy", busy, 1);
        force_byte = 1; force_val = 8'hAB; step();
        prev = m_sample;
        force_tick = 1; step(); step();
        chk("underrun_flag", underrun, 1);
        chk("underrun_sample", sample_out, HOLD ? prev : 16'h0000);
        chk("underrun_level", fifo_level, 1);
        do_stop = 1; step();
        run(5);
        chk("final_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
